// File: rtl/serial_rx_pkg.sv
// rtl/serial_rx_pkg.sv - shared frame constants and receiver FSM states
package serial_rx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        STOP   = 2'd2,
        RESYNC = 2'd3
    } rx_state_e;

    localparam logic START_BIT = 1'b1;
    localparam logic STOP_BIT  = 1'b0;
    localparam logic IDLE_LVL  = 1'b0;

endpackage

// File: rtl/serial_rx_hold_reg.sv
// rtl/serial_rx_hold_reg.sv - one-entry valid/ready holding register with overrun pulse
module rx_hold_reg #(
    parameter int DSIZE = 32
) (
    input  logic             s_clk,
    input  logic             rst,
    input  logic             load,
    input  logic [DSIZE-1:0] load_data,
    input  logic             load_end,
    input  logic             out_ready,
    output logic [DSIZE-1:0] data,
    output logic             pkt_end,
    output logic             valid,
    output logic             overrun
);

    logic accept;
    logic room;

    assign accept = valid & out_ready;
    // A word leaving this cycle frees the slot for a word arriving this cycle.
    assign room   = ~valid | out_ready;

    always_ff @(posedge s_clk) begin
        if (rst) begin
            data    <= '0;
            pkt_end <= 1'b0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= load & ~room;
            if (load && room) begin
                data    <= load_data;
                pkt_end <= load_end;
                valid   <= 1'b1;
            end else if (accept) begin
                valid   <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/serial_rx.sv
// rtl/serial_rx.sv - serial frame receiver: deframer, shifter and packet counter
module serial_rx
    import serial_rx_pkg::*;
#(
    parameter int DSIZE = 32,
    parameter int CNTW  = 16
) (
    input  logic             s_clk,
    input  logic             rst,
    input  logic             s_in,
    output logic [DSIZE-1:0] data,
    output logic             pkt_end,
    output logic             valid,
    input  logic             out_ready,
    output logic             frame_err,
    output logic             overrun,
    output logic [CNTW-1:0]  pkt_cnt
);

    localparam int CW = $clog2(DSIZE + 2);
    localparam logic [CW-1:0] LAST_BIT = CW'(DSIZE);

    rx_state_e      state, state_nxt;
    logic [CW-1:0]  bit_cnt;
    logic [DSIZE:0] shreg;
    logic           good_stop;
    logic           bad_stop;

    always_comb begin
        state_nxt = state;
        good_stop = 1'b0;
        bad_stop  = 1'b0;
        case (state)
            IDLE:   if (s_in == START_BIT) state_nxt = SHIFT;
            SHIFT:  if (bit_cnt == LAST_BIT) state_nxt = STOP;
            STOP: begin
                if (s_in == STOP_BIT) begin
                    good_stop = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    bad_stop  = 1'b1;
                    state_nxt = RESYNC;
                end
            end
            // A high line here is the tail of a broken frame, never a START.
            RESYNC: if (s_in == IDLE_LVL) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge s_clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            frame_err <= bad_stop;
            if (state == IDLE) begin
                bit_cnt <= '0;
            end else if (state == SHIFT) begin
                shreg   <= {shreg[DSIZE-1:0], s_in};
                bit_cnt <= bit_cnt + CW'(1);
            end
        end
    end

    rx_hold_reg #(
        .DSIZE(DSIZE)
    ) u_hold (
        .s_clk    (s_clk),
        .rst      (rst),
        .load     (good_stop),
        .load_data(shreg[DSIZE-1:0]),
        .load_end (shreg[DSIZE]),
        .out_ready(out_ready),
        .data     (data),
        .pkt_end  (pkt_end),
        .valid    (valid),
        .overrun  (overrun)
    );

    always_ff @(posedge s_clk) begin
        if (rst) begin
            pkt_cnt <= '0;
        end else if (valid && out_ready && pkt_end) begin
            pkt_cnt <= pkt_cnt + CNTW'(1);
        end
    end

endmodule

// File: tb/tb_serial_rx.sv
// tb/tb_serial_rx.sv - self-checking bench for serial_rx with a frame-level reference model
module tb_serial_rx;

    localparam int DSIZE = 8;
    localparam int CNTW  = 4;

    logic             s_clk = 1'b0;
    logic             rst = 1'b1;
    logic             s_in = 1'b0;
    logic             out_ready = 1'b0;
    logic [DSIZE-1:0] data;
    logic             pkt_end;
    logic             valid;
    logic             frame_err;
    logic             overrun;
    logic [CNTW-1:0]  pkt_cnt;

    int checks = 0;
    int errors = 0;

    // frame event announced by the driver for the cycle its STOP bit is sampled
    int               ev = 0;
    logic [DSIZE-1:0] ev_data = '0;
    logic             ev_end = 1'b0;

    logic             m_valid = 1'b0;
    logic [DSIZE-1:0] m_data = '0;
    logic             m_end = 1'b0;
    logic             m_over = 1'b0;
    logic             m_ferr = 1'b0;
    logic [CNTW-1:0]  m_cnt = '0;

    serial_rx #(.DSIZE(DSIZE), .CNTW(CNTW)) dut (
        .s_clk    (s_clk),
        .rst      (rst),
        .s_in     (s_in),
        .data     (data),
        .pkt_end  (pkt_end),
        .valid    (valid),
        .out_ready(out_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .pkt_cnt  (pkt_cnt)
    );

    always #5 s_clk = ~s_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Word-level model: whole frames arrive as events, the slot holds one word.
    always @(posedge s_clk) begin : model
        logic acc;
        if (rst) begin
            m_valid = 1'b0; m_data = '0; m_end = 1'b0;
            m_over = 1'b0; m_ferr = 1'b0; m_cnt = '0;
        end else begin
            acc    = m_valid && out_ready;
            m_over = 1'b0;
            m_ferr = (ev == 2);
            if (acc && m_end) m_cnt = m_cnt + 1'b1;
            if (ev == 1 && (!m_valid || out_ready)) begin
                m_valid = 1'b1; m_data = ev_data; m_end = ev_end;
            end else begin
                if (ev == 1) m_over = 1'b1;
                if (acc) m_valid = 1'b0;
            end
        end
        ev = 0;
    end

    always @(posedge s_clk) begin : compare
        #2;
        chk("valid", {31'b0, valid}, {31'b0, m_valid});
        if (m_valid) begin
            chk("data", {24'b0, data}, {24'b0, m_data});
            chk("pkt_end", {31'b0, pkt_end}, {31'b0, m_end});
        end
        chk("overrun", {31'b0, overrun}, {31'b0, m_over});
        chk("frame_err", {31'b0, frame_err}, {31'b0, m_ferr});
        chk("pkt_cnt", {28'b0, pkt_cnt}, {28'b0, m_cnt});
    end

    task automatic drive(input logic b, input int e);
        @(negedge s_clk);
        s_in = b;
        ev   = e;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 0);
    endtask

    task automatic send_frame(input logic [DSIZE-1:0] d, input logic f, input logic stopb);
        logic [DSIZE:0] w;
        w = {f, d};
        drive(1'b1, 0);
        for (int i = DSIZE; i >= 0; i--) drive(w[i], 0);
        ev_data = d;
        ev_end  = f;
        drive(stopb, stopb ? 2 : 1);
    endtask

    task automatic lit_outputs_zero(input string tag);
        chk({tag, "_data"}, {24'b0, data}, 32'h0);
        chk({tag, "_valid"}, {31'b0, valid}, 32'h0);
        chk({tag, "_pkt_end"}, {31'b0, pkt_end}, 32'h0);
        chk({tag, "_ferr"}, {31'b0, frame_err}, 32'h0);
        chk({tag, "_over"}, {31'b0, overrun}, 32'h0);
        chk({tag, "_cnt"}, {28'b0, pkt_cnt}, 32'h0);
    endtask

    initial begin
        idle(3);
        @(posedge s_clk); #2;
        lit_outputs_zero("reset");
        @(negedge s_clk);
        rst = 1'b0;

        // single word: valid at cycle 11, gone the next cycle
        out_ready = 1'b1;
        idle(2);
        send_frame(8'hA5, 1'b0, 1'b0);
        @(posedge s_clk); #2;
        chk("single_valid", {31'b0, valid}, 32'h1);
        chk("single_data", {24'b0, data}, 32'hA5);
        chk("single_end", {31'b0, pkt_end}, 32'h0);
        @(posedge s_clk); #2;
        chk("single_drop", {31'b0, valid}, 32'h0);
        chk("single_cnt", {28'b0, pkt_cnt}, 32'h0);

        // back-to-back three-word packet
        idle(2);
        send_frame(8'h01, 1'b0, 1'b0);
        send_frame(8'h02, 1'b0, 1'b0);
        send_frame(8'h03, 1'b1, 1'b0);
        @(posedge s_clk); #2;
        chk("pkt_last_data", {24'b0, data}, 32'h03);
        chk("pkt_last_end", {31'b0, pkt_end}, 32'h1);
        idle(3);
        chk("pkt_cnt_1", {28'b0, pkt_cnt}, 32'h1);

        // backpressure: second word dropped with one overrun pulse
        out_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0);
        @(posedge s_clk); #2;
        chk("bp_overrun", {31'b0, overrun}, 32'h1);
        chk("bp_data", {24'b0, data}, 32'h11);
        idle(2);
        out_ready = 1'b1;
        idle(2);
        chk("bp_drained", {31'b0, valid}, 32'h0);

        // framing error, line high 3 more cycles, then a good frame held
        send_frame(8'h5A, 1'b0, 1'b1);
        @(posedge s_clk); #2;
        chk("fe_pulse", {31'b0, frame_err}, 32'h1);
        drive(1'b1, 0); drive(1'b1, 0); drive(1'b1, 0);
        out_ready = 1'b0;
        idle(1);
        send_frame(8'h3C, 1'b0, 1'b0);
        @(posedge s_clk); #2;
        chk("fe_next_data", {24'b0, data}, 32'h3C);
        chk("fe_next_valid", {31'b0, valid}, 32'h1);

        // reset after 4 payload bits, with a word still held
        idle(1);
        drive(1'b1, 0);
        drive(1'b0, 0); drive(1'b1, 0); drive(1'b1, 0); drive(1'b0, 0);
        @(negedge s_clk);
        rst = 1'b1; s_in = 1'b0; ev = 0;
        @(posedge s_clk); #2;
        lit_outputs_zero("midrst");
        @(negedge s_clk);
        rst = 1'b0;
        send_frame(8'hFF, 1'b1, 1'b0);
        @(posedge s_clk); #2;
        chk("rst_next_data", {24'b0, data}, 32'hFF);
        chk("rst_next_end", {31'b0, pkt_end}, 32'h1);
        out_ready = 1'b1;
        idle(2);
        chk("rst_next_cnt", {28'b0, pkt_cnt}, 32'h1);

        // counter wrap after 16 flagged words
        @(negedge s_clk);
        rst = 1'b1; ev = 0;
        @(negedge s_clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            send_frame(DSIZE'(i * 7), 1'b1, 1'b0);
            idle(2);
            chk("wrap_cnt", {28'b0, pkt_cnt}, 32'((i + 1) % 16));
            if (i == 14) chk("wrap_cnt_15", {28'b0, pkt_cnt}, 32'hF);
        end
        chk("wrap_cnt_0", {28'b0, pkt_cnt}, 32'h0);

        idle(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
